// File: rtl/matmul_engine_if.sv
// Data-memory bus between the matrix-multiply engine (master) and its memory (slave).
interface matmul_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;

    // mem_re: mem_rdata is valid exactly one cycle later; mem_we: write commits on the edge ending that cycle.
    modport master (output mem_addr, mem_re, mem_we, mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, mem_re, mem_we, mem_wdata, output mem_rdata);
endinterface

// File: rtl/matmul_engine.sv
// Sequential signed matrix multiply C = A*B over a shared single-port memory,
// one MAC per element term, with saturating or wrapping C writes and a sticky overflow flag.
module matmul_engine #(
    parameter int DATA_W   = 8,
    parameter int M        = 2,
    parameter int K        = 2,
    parameter int N        = 2,
    parameter int ADDR_W   = 8,
    parameter int A_OFFSET = 0,
    parameter int B_OFFSET = 16,
    parameter int C_OFFSET = 32,
    parameter int SAT      = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            result_ack,
    output logic            busy,
    output logic            ready,
    output logic            overflow,
    output logic [2:0]      state_dbg,
    matmul_engine_if.master mem
);
    localparam int ACC_W = 2 * DATA_W + $clog2(K) + 1;
    localparam int I_W   = (M > 1) ? $clog2(M) : 1;
    localparam int J_W   = (N > 1) ? $clog2(N) : 1;
    localparam int K_W   = (K > 1) ? $clog2(K) : 1;

    localparam logic [I_W-1:0] I_LAST = I_W'(M - 1);
    localparam logic [J_W-1:0] J_LAST = J_W'(N - 1);
    localparam logic [K_W-1:0] K_LAST = K_W'(K - 1);

    localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-(2 ** (DATA_W - 1)));

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH_A = 3'd1,
        FETCH_B = 3'd2,
        MAC     = 3'd3,
        WRITE   = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state, next_state;

    logic [I_W-1:0]           i;
    logic [J_W-1:0]           j;
    logic [K_W-1:0]           k;
    logic signed [DATA_W-1:0] a_reg;
    logic signed [ACC_W-1:0]  acc;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic                       acc_out_of_range;
    logic [DATA_W-1:0]          c_value;
    logic [ADDR_W-1:0]          a_addr, b_addr, c_addr;

    assign prod     = a_reg * $signed(mem.mem_rdata);
    assign prod_ext = ACC_W'(prod);

    assign acc_out_of_range = (acc > ACC_MAX) || (acc < ACC_MIN);

    always_comb begin
        c_value = acc[DATA_W-1:0];
        if (SAT != 0) begin
            if (acc > ACC_MAX)      c_value = ACC_MAX[DATA_W-1:0];
            else if (acc < ACC_MIN) c_value = ACC_MIN[DATA_W-1:0];
        end
    end

    assign a_addr = ADDR_W'(A_OFFSET) + ADDR_W'(i) * ADDR_W'(K) + ADDR_W'(k);
    assign b_addr = ADDR_W'(B_OFFSET) + ADDR_W'(k) * ADDR_W'(N) + ADDR_W'(j);
    assign c_addr = ADDR_W'(C_OFFSET) + ADDR_W'(i) * ADDR_W'(N) + ADDR_W'(j);

    assign state_dbg = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Control handshake: a start pulse is taken only in IDLE; ready then holds until result_ack is seen in DONE.
    always_comb begin
        next_state    = state;
        busy          = 1'b0;
        ready         = 1'b0;
        mem.mem_re    = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (start) next_state = FETCH_A;
            end
            FETCH_A: begin
                busy         = 1'b1;
                mem.mem_re   = 1'b1;
                mem.mem_addr = a_addr;
                next_state   = FETCH_B;
            end
            FETCH_B: begin
                busy         = 1'b1;
                mem.mem_re   = 1'b1;
                mem.mem_addr = b_addr;
                next_state   = MAC;
            end
            MAC: begin
                busy       = 1'b1;
                next_state = (k == K_LAST) ? WRITE : FETCH_A;
            end
            WRITE: begin
                busy          = 1'b1;
                mem.mem_we    = 1'b1;
                mem.mem_addr  = c_addr;
                mem.mem_wdata = c_value;
                next_state    = (i == I_LAST && j == J_LAST) ? DONE : FETCH_A;
            end
            DONE: begin
                ready = 1'b1;
                if (result_ack) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            i        <= '0;
            j        <= '0;
            k        <= '0;
            a_reg    <= '0;
            acc      <= '0;
            overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        acc      <= '0;
                        overflow <= 1'b0;
                    end
                end
                FETCH_B: a_reg <= $signed(mem.mem_rdata);
                MAC: begin
                    acc <= acc + prod_ext;
                    if (k != K_LAST) k <= k + 1'b1;
                end
                WRITE: begin
                    if (acc_out_of_range) overflow <= 1'b1;
                    acc <= '0;
                    k   <= '0;
                    if (j == J_LAST) begin
                        j <= '0;
                        i <= (i == I_LAST) ? '0 : i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_matmul_engine.sv
// Bench for matmul_engine: a saturating and a wrapping instance share control and
// see identical memories; results are compared with an integer-arithmetic reference.
`timescale 1ns/1ps
module tb_matmul_engine;
    localparam int DW = 8;
    localparam int AW = 8;
    localparam int M  = 2;
    localparam int K  = 2;
    localparam int N  = 2;
    localparam int AO = 0;
    localparam int BO = 16;
    localparam int CO = 32;
    localparam int RUN_CYCLES = M * N * (3 * K + 1);

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic result_ack = 1'b0;
    logic busy0, ready0, ovf0, busy1, ready1, ovf1;
    logic [2:0] st0, st1;

    matmul_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    matmul_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    matmul_engine #(.SAT(1)) u_sat (
        .clk(clk), .reset(reset), .start(start), .result_ack(result_ack),
        .busy(busy0), .ready(ready0), .overflow(ovf0), .state_dbg(st0), .mem(bus0)
    );
    matmul_engine #(.SAT(0)) u_wrap (
        .clk(clk), .reset(reset), .start(start), .result_ack(result_ack),
        .busy(busy1), .ready(ready1), .overflow(ovf1), .state_dbg(st1), .mem(bus1)
    );

    // clock / reset
    always #5 clk = ~clk;

    logic [DW-1:0] mem0 [256];
    logic [DW-1:0] mem1 [256];

    always @(posedge clk) begin
        if (bus0.mem_re) bus0.mem_rdata <= mem0[bus0.mem_addr];
        if (bus0.mem_we) mem0[bus0.mem_addr] <= bus0.mem_wdata;
        if (bus1.mem_re) bus1.mem_rdata <= mem1[bus1.mem_addr];
        if (bus1.mem_we) mem1[bus1.mem_addr] <= bus1.mem_wdata;
    end

    // scoreboard
    int n_checks = 0;
    int n_fail   = 0;
    int rd_cnt   = 0;
    int wr_cnt   = 0;
    int viol     = 0;
    logic [15:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (bus0.mem_re) rd_cnt++;
            if (bus0.mem_re && bus0.mem_we) viol++;
            if (bus1.mem_re && bus1.mem_we) viol++;
            if (!bus0.mem_re && !bus0.mem_we && bus0.mem_addr != '0) viol++;
            if (!bus1.mem_re && !bus1.mem_we && bus1.mem_addr != '0) viol++;
            if (bus0.mem_we) begin
                wr_cnt++;
                check_eq("wr_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0)
                    check_eq("wr_addr_data", {16'd0, bus0.mem_addr, bus0.mem_wdata}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // reference model
    int a_m [M][K];
    int b_m [K][N];
    logic [DW-1:0] exp_sat  [M*N];
    logic [DW-1:0] exp_wrap [M*N];
    logic exp_ovf;

    task automatic model();
        int s;
        exp_ovf = 1'b0;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < N; c++) begin
                s = 0;
                for (int t = 0; t < K; t++) s += a_m[r][t] * b_m[t][c];
                exp_wrap[r*N+c] = 8'(s);
                if (s > 127) begin
                    exp_sat[r*N+c] = 8'h7F;
                    exp_ovf = 1'b1;
                end else if (s < -128) begin
                    exp_sat[r*N+c] = 8'h80;
                    exp_ovf = 1'b1;
                end else begin
                    exp_sat[r*N+c] = 8'(s);
                end
            end
        end
    endtask

    // driver tasks
    task automatic load_mats();
        for (int r = 0; r < M; r++)
            for (int t = 0; t < K; t++) begin
                mem0[AO + r*K + t] = 8'(a_m[r][t]);
                mem1[AO + r*K + t] = 8'(a_m[r][t]);
            end
        for (int t = 0; t < K; t++)
            for (int c = 0; c < N; c++) begin
                mem0[BO + t*N + c] = 8'(b_m[t][c]);
                mem1[BO + t*N + c] = 8'(b_m[t][c]);
            end
        for (int e = 0; e < M*N; e++) begin
            mem0[CO + e] = 8'hAA;
            mem1[CO + e] = 8'hAA;
        end
    endtask

    task automatic set_ident();
        a_m[0][0] = 1; a_m[0][1] = 0; a_m[1][0] = 0; a_m[1][1] = 1;
        b_m[0][0] = 1; b_m[0][1] = 2; b_m[1][0] = 3; b_m[1][1] = 4;
    endtask

    task automatic run_mat(input string name, input bit disturb);
        int cyc;
        int held;
        model();
        load_mats();
        for (int e = 0; e < M*N; e++) exp_q.push_back({8'(CO + e), exp_sat[e]});
        rd_cnt = 0;
        wr_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_eq({name, "_busy"}, 32'(busy0), 32'd1);
        cyc = 0;
        while (!ready0 && cyc < 200) begin
            start      = disturb && (cyc == 1);
            result_ack = disturb && (cyc == 1);
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        result_ack = 1'b0;
        check_eq({name, "_latency"}, 32'(cyc), 32'(RUN_CYCLES));
        check_eq({name, "_ready_wrap"}, 32'(ready1), 32'd1);
        check_eq({name, "_busy_done"}, 32'(busy0), 32'd0);
        check_eq({name, "_ovf_sat"}, 32'(ovf0), 32'(exp_ovf));
        check_eq({name, "_ovf_wrap"}, 32'(ovf1), 32'(exp_ovf));
        for (int e = 0; e < M*N; e++) begin
            check_eq({name, "_c_sat"}, 32'(mem0[CO + e]), 32'(exp_sat[e]));
            check_eq({name, "_c_wrap"}, 32'(mem1[CO + e]), 32'(exp_wrap[e]));
        end
        check_eq({name, "_wr_left"}, 32'(exp_q.size()), 32'd0);
        held = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk) start = disturb && (c == 3);
            @(posedge clk);
            #1;
            if (ready0 && ready1 && ovf0 == exp_ovf && !busy0) held++;
        end
        start = 1'b0;
        check_eq({name, "_done_hold"}, 32'(held), 32'd10);
        @(negedge clk) result_ack = 1'b1;
        @(posedge clk);
        #1 result_ack = 1'b0;
        check_eq({name, "_ack_ready"}, 32'(ready0), 32'd0);
        check_eq({name, "_ack_idle"}, 32'(st0), 32'd0);
        check_eq({name, "_reads"}, 32'(rd_cnt), 32'(2 * M * N * K));
        check_eq({name, "_writes"}, 32'(wr_cnt), 32'(M * N));
    endtask

    task automatic check_quiet(input string name);
        check_eq({name, "_busy"}, 32'(busy0 | busy1), 32'd0);
        check_eq({name, "_ready"}, 32'(ready0 | ready1), 32'd0);
        check_eq({name, "_ovf"}, 32'(ovf0 | ovf1), 32'd0);
        check_eq({name, "_strobes"}, {28'd0, bus0.mem_re, bus0.mem_we, bus1.mem_re, bus1.mem_we}, 32'd0);
        check_eq({name, "_addr"}, {16'd0, bus0.mem_addr, bus1.mem_addr}, 32'd0);
        check_eq({name, "_wdata"}, {16'd0, bus0.mem_wdata, bus1.mem_wdata}, 32'd0);
        check_eq({name, "_state"}, {26'd0, st0, st1}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rb;
        int cyc;
        for (int e = 0; e < 256; e++) begin
            mem0[e] = '0;
            mem1[e] = '0;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_quiet("reset");
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_quiet("idle_wait");

        set_ident();
        run_mat("ident", 1'b0);
        for (int e = 0; e < 4; e++) check_eq("ident_vec", 32'(mem0[CO + e]), 32'(e + 1));

        a_m[0][0] = 100; a_m[0][1] = 100; a_m[1][0] = 0; a_m[1][1] = 0;
        b_m[0][0] = 100; b_m[0][1] = 0;   b_m[1][0] = 100; b_m[1][1] = 0;
        run_mat("ovf", 1'b0);
        check_eq("ovf_vec_sat", 32'(mem0[CO]), 32'h7F);
        check_eq("ovf_vec_wrap", 32'(mem1[CO]), 32'h20);
        check_eq("ovf_vec_flag", 32'(ovf0), 32'd1);

        a_m[0][0] = -3; a_m[0][1] = 0; a_m[1][0] = 0; a_m[1][1] = 0;
        b_m[0][0] = 4;  b_m[0][1] = 0; b_m[1][0] = 0; b_m[1][1] = 0;
        run_mat("signed", 1'b1);
        check_eq("signed_vec", 32'(mem0[CO]), 32'hF4);
        check_eq("signed_ovf", 32'(ovf0), 32'd0);

        for (int r = 0; r < 8; r++) begin
            for (int x = 0; x < M; x++)
                for (int y = 0; y < K; y++) begin
                    rb = 8'($urandom_range(0, 255));
                    a_m[x][y] = int'($signed(rb));
                end
            for (int x = 0; x < K; x++)
                for (int y = 0; y < N; y++) begin
                    rb = 8'($urandom_range(0, 255));
                    b_m[x][y] = int'($signed(rb));
                end
            run_mat("rand", r[0]);
        end

        // abort during the second C write
        set_ident();
        model();
        load_mats();
        exp_q.push_back({8'(CO), exp_sat[0]});
        wr_cnt = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (!(bus0.mem_we && wr_cnt == 1) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check_eq("abort_at_write2", 32'(bus0.mem_we), 32'd1);
        check_eq("abort_write2_addr", 32'(bus0.mem_addr), 32'(CO + 1));
        reset = 1'b0;
        #1 check_quiet("abort");
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        check_eq("abort_c0", 32'(mem0[CO]), 32'd1);
        for (int e = 1; e < 4; e++) begin
            check_eq("abort_c_sat_kept", 32'(mem0[CO + e]), 32'hAA);
            check_eq("abort_c_wrap_kept", 32'(mem1[CO + e]), 32'hAA);
        end
        repeat (5) @(posedge clk);
        #1 check_quiet("abort_idle");
        exp_q.delete();
        run_mat("after_abort", 1'b0);

        check_eq("bus_rules", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
